// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU opcodes and the
// arbiter FSM state encoding.
package alu_share_arbiter_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters. Unused opcodes fall
// back to AND so the datapath never produces an undefined value.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [ALU_W-1:0] src_a,
  input  logic [ALU_W-1:0] src_b,
  input  logic [2:0]       alu_control,
  output logic [ALU_W-1:0] result,
  output logic             zero
);

  always_comb begin
    result = src_a & src_b;
    case (alu_control)
      ALU_ADD: result = src_a + src_b;
      ALU_SUB: result = src_a - src_b;
      ALU_AND: result = src_a & src_b;
      ALU_OR:  result = src_a | src_b;
      ALU_XOR: result = src_a ^ src_b;
      ALU_SLT: result = {{(ALU_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: result = src_a & src_b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters and holds a
// registered response until the owning requester accepts it.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  output logic [1:0]       resp_valid,
  input  logic [1:0]       resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             busy,
  output logic [CNT_W-1:0] done_cnt0,
  output logic [CNT_W-1:0] done_cnt1
);

  logic [1:0]       state;
  logic             last_grant;
  logic             owner;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic [1:0]       grant;
  logic             resp_accept;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready   = (state == ST_IDLE && rst_n) ? grant : 2'b00;
  assign resp_valid  = (state == ST_RESP) ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign busy        = (state != ST_IDLE);
  assign resp_accept = (state == ST_RESP) && resp_ready[owner];

  alu_share_arbiter_alu u_alu (
    .src_a       (op_a),
    .src_b       (op_b),
    .alu_control (op_code),
    .result      (alu_result),
    .zero        (alu_zero)
  );

  // Reset drops any in-flight operation; requesters must reissue afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      last_grant  <= 1'b1;
      owner       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      op_code     <= ALU_ADD;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      done_cnt0   <= '0;
      done_cnt1   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            owner   <= grant[1];
            op_a    <= grant[1] ? req_a1  : req_a0;
            op_b    <= grant[1] ? req_b1  : req_b0;
            op_code <= grant[1] ? req_op1 : req_op0;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          state       <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_accept) begin
            last_grant <= owner;
            if (owner) done_cnt1 <= done_cnt1 + CNT_W'(1);
            else       done_cnt0 <= done_cnt0 + CNT_W'(1);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with hand-computed
// expected values.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
  logic [31:0] req_a0, req_b0, req_a1, req_b1, resp_result;
  logic [2:0]  req_op0, req_op1;
  logic        resp_zero, busy;
  logic [15:0] done_cnt0, done_cnt1;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a0      (req_a0),
    .req_b0      (req_b0),
    .req_a1      (req_a1),
    .req_b1      (req_b1),
    .req_op0     (req_op0),
    .req_op1     (req_op1),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_zero   (resp_zero),
    .busy        (busy),
    .done_cnt0   (done_cnt0),
    .done_cnt1   (done_cnt1)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vec_cnt++;
    assert (observed === expected) else begin
      err_cnt++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                               input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1);
    req_valid = valid;
    req_a0 = a0; req_b0 = b0; req_op0 = op0;
    req_a1 = a1; req_b1 = b1; req_op1 = op1;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full handshake: grant, EXEC, RESP with the expected response, then accept.
  task automatic runOp(input string tag, input logic [1:0] exp_grant,
                       input logic [31:0] exp_result, input logic exp_zero);
    checkOutput({tag, ".req_ready"}, 64'(req_ready), 64'(exp_grant));
    tick();
    checkOutput({tag, ".busy_exec"}, 64'(busy), 64'(1'b1));
    checkOutput({tag, ".ready_exec"}, 64'(req_ready), 64'(2'b00));
    tick();
    checkOutput({tag, ".resp_valid"}, 64'(resp_valid), 64'(exp_grant));
    checkOutput({tag, ".result"}, 64'(resp_result), 64'(exp_result));
    checkOutput({tag, ".zero"}, 64'(resp_zero), 64'(exp_zero));
    resp_ready = exp_grant;
    tick();
    resp_ready = 2'b00;
    checkOutput({tag, ".resp_cleared"}, 64'(resp_valid), 64'(2'b00));
    checkOutput({tag, ".busy_idle"}, 64'(busy), 64'(1'b0));
    checkOutput({tag, ".result_hold"}, 64'(resp_result), 64'(exp_result));
  endtask

  initial begin
    rst_n = 1'b0;
    resp_ready = 2'b00;
    applyStimulus(2'b00, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0, ALU_ADD);
    checkOutput("rst.req_ready", 64'(req_ready), 64'(2'b00));
    checkOutput("rst.resp_valid", 64'(resp_valid), 64'(2'b00));
    checkOutput("rst.result", 64'(resp_result), 64'(32'd0));
    checkOutput("rst.zero", 64'(resp_zero), 64'(1'b0));
    checkOutput("rst.busy", 64'(busy), 64'(1'b0));
    checkOutput("rst.cnt0", 64'(done_cnt0), 64'(16'd0));
    checkOutput("rst.cnt1", 64'(done_cnt1), 64'(16'd0));
    tick();
    tick();
    rst_n = 1'b1;

    // Single add from requester 0, then subtract-to-zero and SLT from requester 1
    applyStimulus(2'b01, 32'd5, 32'd7, ALU_ADD, 32'd0, 32'd0, ALU_ADD);
    runOp("add", 2'b01, 32'd12, 1'b0);
    checkOutput("add.cnt0", 64'(done_cnt0), 64'(16'd1));
    applyStimulus(2'b10, 32'd0, 32'd0, ALU_ADD, 32'h10, 32'h10, ALU_SUB);
    runOp("sub0", 2'b10, 32'd0, 1'b1);
    checkOutput("sub0.cnt1", 64'(done_cnt1), 64'(16'd1));
    applyStimulus(2'b10, 32'd0, 32'd0, ALU_ADD, 32'hFFFF_FFFF, 32'd1, ALU_SLT);
    runOp("slt", 2'b10, 32'd1, 1'b0);
    checkOutput("slt.cnt1", 64'(done_cnt1), 64'(16'd2));
    checkOutput("slt.cnt0", 64'(done_cnt0), 64'(16'd1));

    // Tie fairness from a fresh reset
    rst_n = 1'b0;
    #1;
    checkOutput("rst2.cnt0", 64'(done_cnt0), 64'(16'd0));
    checkOutput("rst2.cnt1", 64'(done_cnt1), 64'(16'd0));
    tick();
    rst_n = 1'b1;
    applyStimulus(2'b11, 32'd1, 32'd2, ALU_ADD, 32'd10, 32'd3, ALU_SUB);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) runOp("fair", 2'b01, 32'd3, 1'b0);
      else            runOp("fair", 2'b10, 32'd7, 1'b0);
    end
    checkOutput("fair.cnt0", 64'(done_cnt0), 64'(16'd2));
    checkOutput("fair.cnt1", 64'(done_cnt1), 64'(16'd2));

    // Backpressure: response held while owner withholds resp_ready
    checkOutput("bp.req_ready", 64'(req_ready), 64'(2'b01));
    tick();
    tick();
    applyStimulus(2'b11, 32'd100, 32'd2, ALU_ADD, 32'd10, 32'd3, ALU_SUB);
    for (int i = 0; i < 10; i++) begin
      resp_ready = (i < 5) ? 2'b00 : 2'b10;
      tick();
      checkOutput("bp.resp_valid", 64'(resp_valid), 64'(2'b01));
      checkOutput("bp.result", 64'(resp_result), 64'(32'd3));
      checkOutput("bp.req_ready", 64'(req_ready), 64'(2'b00));
      checkOutput("bp.cnt0", 64'(done_cnt0), 64'(16'd2));
      checkOutput("bp.cnt1", 64'(done_cnt1), 64'(16'd2));
    end
    resp_ready = 2'b01;
    tick();
    resp_ready = 2'b00;
    checkOutput("bp.resp_cleared", 64'(resp_valid), 64'(2'b00));
    checkOutput("bp.cnt0_done", 64'(done_cnt0), 64'(16'd3));

    // Reset during EXEC
    checkOutput("rmid.req_ready", 64'(req_ready), 64'(2'b10));
    tick();
    checkOutput("rmid.busy_exec", 64'(busy), 64'(1'b1));
    rst_n = 1'b0;
    #1;
    checkOutput("rmid.busy", 64'(busy), 64'(1'b0));
    checkOutput("rmid.req_ready", 64'(req_ready), 64'(2'b00));
    checkOutput("rmid.resp_valid", 64'(resp_valid), 64'(2'b00));
    checkOutput("rmid.result", 64'(resp_result), 64'(32'd0));
    checkOutput("rmid.zero", 64'(resp_zero), 64'(1'b0));
    checkOutput("rmid.cnt0", 64'(done_cnt0), 64'(16'd0));
    checkOutput("rmid.cnt1", 64'(done_cnt1), 64'(16'd0));
    rst_n = 1'b1;
    #1;
    checkOutput("rmid.first_tie", 64'(req_ready), 64'(2'b01));

    // Add wraparound and an unused opcode that behaves as AND
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, ALU_ADD, 32'd0, 32'd0, ALU_ADD);
    runOp("wrap", 2'b01, 32'd0, 1'b1);
    applyStimulus(2'b01, 32'h0000_00F0, 32'h0000_003C, 3'b111, 32'd0, 32'd0, ALU_ADD);
    runOp("op111", 2'b01, 32'h0000_0030, 1'b0);
    checkOutput("end.cnt0", 64'(done_cnt0), 64'(16'd2));
    applyStimulus(2'b00, 32'd0, 32'd0, ALU_ADD, 32'd0, 32'd0, ALU_ADD);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
